// File: rtl/audio_dac_serializer_pkg.sv
// Shared constants and sample type for the audio output path.
package audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  // bit_cnt bit that selects the channel (0 = left, 1 = right)
  localparam int CH_BIT     = $clog2(SLOT_BITS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample inputs and codec-side outputs of the DAC serializer.
interface audio_dac_serializer_if;
  import audio_pkg::*;

  sample_t left_in;
  sample_t right_in;
  logic    mute;
  logic    aud_bclk;
  logic    aud_daclrck;
  logic    aud_dacdat;
  logic    sample_tick;

  modport master (
    output left_in, right_in, mute,
    input  aud_bclk, aud_daclrck, aud_dacdat, sample_tick
  );

  modport slave (
    input  left_in, right_in, mute,
    output aud_bclk, aud_daclrck, aud_dacdat, sample_tick
  );
endinterface

// File: rtl/audio_dac_serializer_bclk_gen.sv
// Divides the system clock down to the codec bit clock and flags each falling edge.
module audio_bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic clock,
  input  logic reset,
  output logic aud_bclk,
  output logic fall_strobe
);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             wrap;

  assign wrap = (div_cnt_reg == DIV_W'(BCLK_HALF - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // High in the cycle whose closing edge drives BCLK low, so the top can
  // update data on that same edge.
  assign fall_strobe = wrap & bclk_reg;
  assign aud_bclk    = bclk_reg;
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S serializer: latches one L/R pair per frame and shifts it MSB-first with a one-bit delay.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  audio_dac_serializer_if.slave  aud
);
  logic       fall_strobe;
  logic [5:0] bit_cnt_reg;
  logic [5:0] bit_cnt_next;
  sample_t    shadow_l_reg;
  sample_t    shadow_r_reg;
  sample_t    cur_shadow;
  logic       daclrck_reg;
  logic       dacdat_reg;
  logic       sample_tick_reg;
  logic [4:0] slot_pos;
  logic [3:0] shadow_idx;
  logic       dat_next;
  logic       latch;

  audio_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clock       (clock),
    .reset       (reset),
    .aud_bclk    (aud.aud_bclk),
    .fall_strobe (fall_strobe)
  );

  always_comb begin
    bit_cnt_next = bit_cnt_reg + 6'd1;
    slot_pos     = bit_cnt_next[4:0];
    shadow_idx   = 4'(5'(SAMPLE_W) - slot_pos);
    cur_shadow   = bit_cnt_next[CH_BIT] ? shadow_r_reg : shadow_l_reg;
    dat_next     = 1'b0;
    // Slot bit 0 is the I2S delay bit; bits past the sample word are padding.
    if (slot_pos >= 5'd1 && slot_pos <= 5'(SAMPLE_W))
      dat_next = cur_shadow[shadow_idx];
    latch = fall_strobe && (bit_cnt_reg == 6'(FRAME_BITS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_reg     <= '0;
      shadow_l_reg    <= '0;
      shadow_r_reg    <= '0;
      daclrck_reg     <= 1'b0;
      dacdat_reg      <= 1'b0;
      sample_tick_reg <= 1'b0;
    end else begin
      sample_tick_reg <= latch;
      if (fall_strobe) begin
        bit_cnt_reg <= bit_cnt_next;
        daclrck_reg <= bit_cnt_next[CH_BIT];
        dacdat_reg  <= dat_next;
      end
      if (latch) begin
        shadow_l_reg <= aud.mute ? '0 : aud.left_in;
        shadow_r_reg <= aud.mute ? '0 : aud.right_in;
      end
    end
  end

  assign aud.aud_daclrck = daclrck_reg;
  assign aud.aud_dacdat  = dacdat_reg;
  assign aud.sample_tick = sample_tick_reg;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer with a frame scoreboard decoded on BCLK rises.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int HALF = 2;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  audio_dac_serializer_if aud();

  audio_dac_serializer #(
    .BCLK_HALF (HALF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .aud   (aud)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected frame contents {left, right}, one entry per frame since release.
  logic [31:0] exp_q[$];

  // Monitor state
  logic        mon_en = 1'b0;
  int          rise_cnt;
  logic        bclk_prev;
  logic [5:0]  pos;
  logic [4:0]  kk;
  logic [15:0] got_l;
  logic [15:0] got_r;
  logic        got_pad;
  logic [31:0] exp_w;

  always @(negedge clock) begin
    if (!mon_en) begin
      rise_cnt  = 0;
      bclk_prev = 1'b0;
      got_l     = '0;
      got_r     = '0;
      got_pad   = 1'b0;
    end else begin
      if (aud.aud_bclk && !bclk_prev) begin
        pos = 6'(rise_cnt % 64);
        kk  = pos[4:0];
        total++;
        assert (aud.aud_daclrck === pos[5]) else begin
          bad++;
          $error("FAIL lrck rise=%0d got=%b exp=%b", rise_cnt, aud.aud_daclrck, pos[5]);
        end
        if (kk >= 5'd1 && kk <= 5'd16) begin
          if (pos[5]) got_r[16 - kk] = aud.aud_dacdat;
          else        got_l[16 - kk] = aud.aud_dacdat;
        end else if (aud.aud_dacdat !== 1'b0) begin
          got_pad = 1'b1;
        end
        rise_cnt++;
        if (pos == 6'd63) begin
          total++;
          assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL frame_unexpected got=%h_%h exp=none", got_l, got_r);
          end
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            total++;
            assert ({got_l, got_r, got_pad} === {exp_w, 1'b0}) else begin
              bad++;
              $error("FAIL frame%0d got=%h_%h pad=%b exp=%h_%h pad=0",
                     rise_cnt / 64 - 1, got_l, got_r, got_pad, exp_w[31:16], exp_w[15:0]);
            end
          end
          got_l   = '0;
          got_r   = '0;
          got_pad = 1'b0;
        end
      end
      bclk_prev = aud.aud_bclk;
    end
  end

  task automatic set_in(input logic [15:0] l, input logic [15:0] r, input logic m);
    aud.left_in  = l;
    aud.right_in = r;
    aud.mute     = m;
    exp_q.push_back(m ? 32'h0 : {l, r});
  endtask

  task automatic wait_rise(input int target);
    int n = 0;
    while (rise_cnt < target && n < 4000) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    assert (rise_cnt >= target) else begin
      bad++;
      $error("FAIL wait_rise got=%0d exp=%0d", rise_cnt, target);
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    assert ({aud.aud_bclk, aud.aud_daclrck, aud.aud_dacdat, aud.sample_tick} === 4'b0000) else begin
      bad++;
      $error("FAIL %s got=%b%b%b%b exp=0000", tag, aud.aud_bclk, aud.aud_daclrck,
             aud.aud_dacdat, aud.sample_tick);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Release reset right after a posedge; frame 0 is zeros, frames 1 and 2
  // latch whatever inputs are present (held constant through timing_check).
  task automatic release_reset();
    @(posedge clock); #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(aud.mute ? 32'h0 : {aud.left_in, aud.right_in});
    exp_q.push_back(aud.mute ? 32'h0 : {aud.left_in, aud.right_in});
  endtask

  task automatic timing_check(input string tag);
    int   rise1 = -1, fall1 = -1, rise2 = -1, lr_up = -1, lr_dn = -1;
    int   tick1 = -1, tick2 = -1, tick_n = 0;
    logic pb = 1'b0, pl = 1'b0;
    for (int c = 1; c <= 520; c++) begin
      @(posedge clock); #1;
      if (aud.aud_bclk && !pb) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      if (!aud.aud_bclk && pb && fall1 < 0) fall1 = c;
      if (aud.aud_daclrck && !pl && lr_up < 0) lr_up = c;
      if (!aud.aud_daclrck && pl && lr_dn < 0) lr_dn = c;
      if (aud.sample_tick) begin
        tick_n++;
        if (tick1 < 0) tick1 = c;
        else if (tick2 < 0) tick2 = c;
      end
      pb = aud.aud_bclk;
      pl = aud.aud_daclrck;
    end
    check_int({tag, "_first_rise"}, rise1, 2 * HALF / 2);
    check_int({tag, "_first_fall"}, fall1, 2 * HALF);
    check_int({tag, "_bclk_period"}, rise2 - rise1, 2 * HALF);
    check_int({tag, "_lrck_low"}, lr_up, 64 * HALF);
    check_int({tag, "_lrck_high"}, lr_dn - lr_up, 64 * HALF);
    check_int({tag, "_tick_first"}, tick1, 128 * HALF);
    check_int({tag, "_tick_period"}, tick2 - tick1, 128 * HALF);
    check_int({tag, "_tick_count"}, tick_n, 2);
  endtask

  initial begin
    reset        = 1'b1;
    aud.left_in  = '0;
    aud.right_in = '0;
    aud.mute     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset_idle");

    release_reset();
    timing_check("run1");

    // Frame 3: serialization pattern
    wait_rise(64 * 2 + 40);
    set_in(16'hA5C3, 16'h8001, 1'b0);
    // Change mid-left slot of frame 3: frame 3 keeps A5C3, frame 4 shows 1234
    wait_rise(64 * 3 + 8);
    set_in(16'h1234, 16'h8001, 1'b0);
    // Mute held across the latch: frame 5 is all zeros
    wait_rise(64 * 4 + 20);
    set_in(16'h7FFF, 16'h7FFF, 1'b1);
    // Frame 6 unmuted; mid-frame mute pulses must not matter
    wait_rise(64 * 5 + 20);
    set_in(16'h7FFF, 16'h5555, 1'b0);
    wait_rise(64 * 5 + 50);
    aud.mute = 1'b1;
    @(posedge clock); #1;
    aud.mute = 1'b0;
    wait_rise(64 * 6 + 20);
    set_in(16'hC000, 16'h0001, 1'b0);

    // Reset while right slot bit 9 of frame 7 is on the wire
    wait_rise(64 * 7 + 42);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(posedge clock); #1;
    check_idle("midframe_reset");
    exp_q.delete();
    @(posedge clock); #1;
    check_idle("midframe_reset_hold");

    release_reset();
    timing_check("run2");
    wait_rise(64 * 2 + 40);
    set_in(16'h8000, 16'h7FFF, 1'b0);
    wait_rise(64 * 4);
    @(posedge clock); #1;
    check_int("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Downstream consumer of the noise/envelope voices. Latches one signed 16-bit left/right sample pair per audio frame and shifts it out MSB-first in I2S format to the board audio codec DAC (BCLK, DACLRCK, DACDAT). It generates all codec bit clocks from the system `clock`. It emits a one-cycle `sample_tick` at each latch so upstream envelope and filter stages can step at the true sample rate.

## Interface
- `BCLK_HALF`, default 8: system clocks per BCLK half-period; must be ≥1.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `left_in`  in  16  signed left sample; free-running, sampled only at latch.
- `right_in`  in  16  signed right sample; free-running, sampled only at latch.
- `mute`  in  1  when high at latch, the frame latches zeros.
- `aud_bclk`  out  1  codec bit clock, registered.
- `aud_daclrck`  out  1  0 = left slot, 1 = right slot, registered.
- `aud_dacdat`  out  1  serial data, registered.
- `sample_tick`  out  1  one-clock pulse on the latch cycle.

## Operation
- `div_cnt` counts 0..BCLK_HALF-1.
- At BCLK_HALF-1, `div_cnt` wraps to 0 and `aud_bclk` toggles.
- A toggle 1→0 is a **fall event**. At each fall event:
  - `bit_cnt` (6 bits, 0..63) increments modulo 64.
  - `aud_daclrck` and `aud_dacdat` update in the same clock.
- Slot position is k = `bit_cnt`[4:0]. Channel is `bit_cnt`[5]: 0 = left, 1 = right.
- `aud_daclrck` = `bit_cnt`[5] (new value).
- I2S one-bit delay applies:
  - k = 1..16: `aud_dacdat` = shadow[16-k] of the current channel.
  - k = 0 and k = 17..31: `aud_dacdat` = 0.
- **Latch** is the fall event where `bit_cnt` goes 63→0. On that cycle:
  - `shadow_l` ← `mute` ? 0 : `left_in`, and `shadow_r` ← `mute` ? 0 : `right_in`.
  - `sample_tick` = 1 for that single clock.
- Inputs that change between latches never affect the frame in flight.
- The codec samples on BCLK rising edges. Data is stable for BCLK_HALF clocks before each rise.
- No arithmetic on sample values. Bits are passed through unchanged, two's complement.

## Timing
- Reset values:
  - `aud_bclk` = 0, `aud_daclrck` = 0, `aud_dacdat` = 0, `sample_tick` = 0.
  - `div_cnt` = 0, `bit_cnt` = 0, shadows = 0.
- Reset is synchronous and may be asserted mid-frame. All state returns to reset values on the next posedge. No partial word is emitted after reset deasserts.
- After reset deasserts:
  - First toggle (BCLK rise) occurs BCLK_HALF clocks later.
  - First fall event occurs 2·BCLK_HALF clocks later, with `bit_cnt` = 1.
- First latch occurs at fall event 64, i.e. 128·BCLK_HALF clocks after reset deassertion. The frame before it carries zeros.
- Rates:
  - BCLK period = 2·BCLK_HALF clocks.
  - Frame (LRCK period) = 128·BCLK_HALF clocks.
  - `sample_tick` period = 128·BCLK_HALF clocks, exactly one pulse per frame.
- Latency: a sample latched at fall event 0 has its left MSB on `aud_dacdat` at fall event 1, i.e. 2·BCLK_HALF clocks after latch. Right MSB is at fall event 33.
- `mute` is sampled only on the latch cycle. Toggling it mid-frame has no effect until the next latch.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_W` = 16, `SLOT_BITS` = 32, `FRAME_BITS` = 64.
  - Typedef `sample_t` = signed [15:0].
- Sub-module `audio_bclk_gen`:
  - Contains `div_cnt` and the `aud_bclk` toggle.
  - Outputs `aud_bclk` and a one-clock `fall_strobe`.
- Top level holds `bit_cnt`, shadows, output mux and `sample_tick`.

## Test plan
- **Reset values:** reset held 3 clocks → all outputs 0. With BCLK_HALF=2, first `aud_bclk` rise is 2 clocks after release and first fall is 4 clocks after release.
- **Frame timing (BCLK_HALF=2):**
  - BCLK period is 4 clocks.
  - `aud_daclrck` is low 128 clocks and high 128 clocks.
  - `sample_tick` pulses exactly every 256 clocks, 1 clock wide, coincident with `aud_daclrck` 1→0.
- **Serialization:** `left_in`=16'hA5C3, `right_in`=16'h8001 held across a latch. Decode on BCLK rises:
  - Left slot bits 1..16 = A5C3; right slot bits 1..16 = 8001.
  - Slot bit 0 and bits 17..31 = 0.
- **Hold:** change `left_in` to 16'h1234 at mid-left slot → current frame still shows A5C3; next frame shows 1234.
- **Mute:** `mute`=1 across a latch with `left_in`=16'h7FFF → following frame all zeros. `mute` pulsed mid-frame only → no effect.
- **Reset mid-frame:** assert reset during right slot bit 9 → next clock all outputs 0 and counters 0. Re-run the frame-timing check from release.
